booth_mult_sched: RTL and testbench

Shared-resource scheduler for the team's iterative radix-2 Booth multiplier. It accepts signed multiply requests from `N_REQ` independent requesters and grants the single Booth engine round-robin. It sequences one Booth iteration per clock and returns the tagged 2·`WIDTH`-bit signed product over a valid/ready response channel. It sits between the requesting control FSMs and the arithmetic datapath, so no requester drives the multiplier directly.

---
 rtl/booth_mult_sched.sv | 165 ++++++++++++++++
 tb/tb_booth_mult_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_sched.sv
// Round-robin scheduler wrapped around a single iterative radix-2 Booth engine.
// One Booth iteration per clock; products return on a tagged valid/ready channel.
module booth_mult_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*WIDTH-1:0]        req_mr,
  input  logic [N_REQ*WIDTH-1:0]        req_md,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(N_REQ)-1:0]      rsp_id,
  output logic signed [2*WIDTH-1:0]     rsp_prod,
  output logic                          busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

  state_t                    state_q, state_d;
  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]            id_q, id_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic signed [2*WIDTH-1:0] rsp_prod_q, rsp_prod_d;

  logic signed [WIDTH:0]     acc_q, acc_d;
  logic signed [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]          q_q, q_d;
  logic                      q1_q, q1_d;

  logic                      sel_found;
  logic [IDW-1:0]            sel_idx;
  logic [WIDTH-1:0]          sel_mr, sel_md;
  logic [2*WIDTH+1:0]        booth_next;
  int                        scan_idx;

  // One Booth step: add/subtract per {q0,q_1}, then arithmetic shift of {acc,q,q_1}.
  function automatic logic [2*WIDTH+1:0] booth_step(
    input logic signed [WIDTH:0] acc,
    input logic [WIDTH-1:0]      q,
    input logic                  q1,
    input logic signed [WIDTH:0] m
  );
    logic signed [WIDTH:0]     sum;
    logic signed [2*WIDTH+1:0] cat;
    case ({q[0], q1})
      2'b10:   sum = acc - m;
      2'b01:   sum = acc + m;
      default: sum = acc;
    endcase
    cat = {sum, q, q1};
    return cat >>> 1;
  endfunction

  // Round-robin search starting at rr_ptr, wrapping at N_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!sel_found && req_valid[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(scan_idx);
      end
    end
  end

  assign sel_mr = req_mr[int'(sel_idx)*WIDTH +: WIDTH];
  assign sel_md = req_md[int'(sel_idx)*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == S_IDLE && sel_found) req_ready[sel_idx] = 1'b1;
  end

  assign booth_next = booth_step(acc_q, q_q, q1_q, m_q);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_prod_d  = rsp_prod_q;
    acc_d       = acc_q;
    m_d         = m_q;
    q_d         = q_q;
    q1_d        = q1_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          id_d    = sel_idx;
          q_d     = sel_mr;
          m_d     = {sel_md[WIDTH-1], sel_md};
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_d   = '0;
        q1_d    = 1'b0;
        cnt_d   = CW'(WIDTH);
        state_d = S_RUN;
      end
      S_RUN: begin
        acc_d = booth_next[2*WIDTH+1:WIDTH+1];
        q_d   = booth_next[WIDTH:1];
        q1_d  = booth_next[0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          rsp_prod_d  = booth_next[2*WIDTH:1];
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_prod_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_prod_q  <= rsp_prod_d;
    end
  end

  // Arithmetic datapath carries no reset; LOAD initialises it before use.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    m_q   <= m_d;
    q_q   <= q_d;
    q1_q  <= q1_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_prod  = rsp_prod_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_booth_mult_sched.sv
// Bench for booth_mult_sched: table vectors, grant-order sequences, stall, reset
// mid-run, and randomized traffic against a product/round-robin reference model.
module tb_booth_mult_sched;
  localparam int N = 4;
  localparam int W = 4;

  logic               clk;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_mr, req_md;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [2*W-1:0]     rsp_prod;
  logic               busy;

  logic signed [W-1:0] op_mr [N];
  logic signed [W-1:0] op_md [N];

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int grants[$];
  int last_id;
  logic [2*W-1:0] last_prod;

  booth_mult_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mr(req_mr), .req_md(req_md),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_prod(rsp_prod), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_mr[i*W +: W] = op_mr[i];
      req_md[i*W +: W] = op_md[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_op(input int i);
    op_mr[i] = W'($urandom);
    op_md[i] = W'($urandom);
  endtask

  // Runs until nops responses have been handed off. Entry/exit about 1 unit after a posedge.
  // stall_n < 0 picks a random stall of 0..3 cycles per response.
  task automatic run_ops(input int nops, input logic [N-1:0] vmask, input int stall_n);
    int done = 0, upd = -1, acc_cyc = 0, stall_left = 0, sel, budget;
    bit outstanding = 0, seen = 0, found;
    logic [N-1:0] exp_rdy;
    int exp_id = 0;
    logic [2*W-1:0] exp_prod = '0;
    budget = nops * (W + 12) + 20;
    req_valid = vmask;
    for (int cyc = 0; cyc < budget && done < nops; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      if (upd >= 0) begin
        req_valid[upd] = vmask[upd];
        rand_op(upd);
        upd = -1;
      end
      rsp_ready = 1'b0;
      #1;
      exp_rdy = '0;
      found = 0;
      sel = 0;
      if (!outstanding) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(ptr_m + k) % N]) begin
            found = 1;
            sel = (ptr_m + k) % N;
          end
        end
        if (found) exp_rdy[sel] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(outstanding));
      if (!outstanding) begin
        chk("rsp_valid_idle", 32'(rsp_valid), 0);
        if (found) begin
          outstanding = 1;
          seen = 0;
          exp_id = sel;
          exp_prod = (2*W)'(int'(op_mr[sel]) * int'(op_md[sel]));
          acc_cyc = cyc;
          stall_left = (stall_n < 0) ? int'($urandom_range(0, 3)) : stall_n;
          grants.push_back(sel);
          upd = sel;
        end
      end else begin
        if (!seen) begin
          if (rsp_valid || cyc >= acc_cyc + W + 2) begin
            chk("latency", 32'(cyc), 32'(acc_cyc + W + 2));
            if (rsp_valid) seen = 1;
          end
        end else begin
          chk("rsp_valid_hold", 32'(rsp_valid), 1);
        end
        if (seen) begin
          chk("rsp_id", 32'(rsp_id), 32'(exp_id));
          chk("rsp_prod", 32'(rsp_prod), 32'(exp_prod));
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            rsp_ready = 1'b1;
            ptr_m = (exp_id + 1) % N;
            outstanding = 0;
            last_id = int'(rsp_id);
            last_prod = rsp_prod;
            done++;
          end
        end
      end
    end
    chk("ops_completed", 32'(done), 32'(nops));
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    int               req;
    logic signed [W-1:0] mr;
    logic signed [W-1:0] md;
    logic [2*W-1:0]   prod;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1,  4'sd3, -4'sd2, 8'hFA};
    vecs[1] = '{0, -4'sd8, -4'sd8, 8'h40};
    vecs[2] = '{2,  4'sd7, -4'sd8, 8'hC8};
    vecs[3] = '{0,  4'sd0,  4'sd5, 8'h00};
    vecs[4] = '{2, -4'sd1, -4'sd1, 8'h01};
    vecs[5] = '{1,  4'sd7,  4'sd7, 8'h31};
    vecs[6] = '{0, -4'sd3,  4'sd5, 8'hF1};
    vecs[7] = '{3, -4'sd8,  4'sd7, 8'hC8};

    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) rand_op(i);
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_prod", 32'(rsp_prod), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    grants.delete();
    run_ops(4, 4'hF, 0);
    for (int i = 0; i < 4; i++) chk("order_all", 32'(grants[i]), 32'(i));

    foreach (vecs[v]) begin
      op_mr[vecs[v].req] = vecs[v].mr;
      op_md[vecs[v].req] = vecs[v].md;
      run_ops(1, 4'(1 << vecs[v].req), 0);
      chk("vec_id", 32'(last_id), 32'(vecs[v].req));
      chk("vec_prod", 32'(last_prod), 32'(vecs[v].prod));
    end

    grants.delete();
    for (int i = 0; i < N; i++) rand_op(i);
    run_ops(4, 4'b0101, 0);
    for (int i = 0; i < 4; i++) chk("order_alt", 32'(grants[i]), 32'((i % 2) * 2));

    run_ops(2, 4'hF, 5);

    for (int r = 0; r < 20; r++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) rand_op(i);
      run_ops(3, m, -1);
    end

    // Leave rr_ptr at 3 so a stale pointer would pick requester 3 after reset.
    op_mr[2] = 4'sd2;
    op_md[2] = 4'sd2;
    run_ops(1, 4'b0100, 0);
    req_valid = 4'b0100;
    op_mr[2] = -4'sd5;
    op_md[2] = 4'sd3;
    #1;
    for (int wt = 0; wt < 20 && req_ready !== 4'b0100; wt++) begin
      @(posedge clk);
      #2;
    end
    chk("pre_rst_grant", 32'(req_ready), 32'(4'b0100));
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("midrun_busy", 32'(busy), 0);
    chk("midrun_rsp_valid", 32'(rsp_valid), 0);
    chk("midrun_rsp_prod", 32'(rsp_prod), 0);
    chk("midrun_rsp_id", 32'(rsp_id), 0);
    chk("midrun_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    ptr_m = 0;
    @(posedge clk);
    #1;
    op_mr[1] = 4'sd5; op_md[1] = 4'sd5;
    op_mr[3] = 4'sd5; op_md[3] = 4'sd5;
    run_ops(1, 4'b1010, 0);
    chk("post_rst_id", 32'(last_id), 1);
    chk("post_rst_prod", 32'(last_prod), 32'h19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
